// File: rtl/udp_pkg.sv
// Shared definitions for the UDP send buffer: FSM state encoding, default
// payload address/data widths and the saturating drop-counter adder.
package udp_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Adds a small increment to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/udp_send_ram.sv
// Payload store for the UDP send buffer.
// Simple dual-port RAM, 2**ADDR_W x DATA_W, one write port and one read port
// with a registered read (data appears the cycle after rd_en). The array has
// no reset so it maps onto block RAM.
// Ports:
//   clk      clock
//   wr_en    write strobe; wr_addr / wr_data select and carry the byte
//   rd_en    read strobe; rd_addr selects the byte
//   rd_data  registered read data
module udp_send_ram import udp_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_send_buffer.sv
// UDP send buffer: collects NTP payload bytes written by address, and on the
// command-end strobe requests a frame from the UDP TX framer, then streams the
// payload out as a valid/ready byte stream with a last marker.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wr_req/i_wr_addr/i_data_in payload byte write
//   i_send_num, i_cmd_end        payload length and "send it" strobe
//   o_tx_req, o_tx_len, i_tx_ack frame request handshake with the framer
//   o_tx_valid/o_tx_data/o_tx_last, i_tx_ready  payload byte stream
//   o_busy                       high whenever a frame is pending or streaming
//   o_drop_cnt                   saturating count of ignored commands/writes
module udp_send_buffer import udp_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [ADDR_W-1:0] i_send_num,
  input  logic              i_cmd_end,
  output logic              o_tx_req,
  output logic [ADDR_W-1:0] o_tx_len,
  input  logic              i_tx_ack,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_last,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len, rd_cnt;
  logic [TMR_W-1:0]  timer;
  logic [7:0]        drop_cnt;
  logic [1:0]        fcnt;
  logic [2:0]        occ_nxt;
  logic              wr_en, issue, issue_last, accept_cmd, timeout, busy_evt;
  logic              push, pop;
  logic [1:0]        drop_inc;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p0, last_p0;
  logic [DATA_W-1:0] e0_data, e1_data;
  logic              e0_last, e1_last;

  udp_send_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (i_wr_addr),
    .wr_data (i_data_in),
    .rd_en   (issue),
    .rd_addr (rd_cnt),
    .rd_data (data_p0)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    issue      = 1'b0;
    accept_cmd = 1'b0;
    timeout    = 1'b0;
    busy_evt   = 1'b0;
    pop        = (fcnt != 2'd0) && i_tx_ready;
    push       = vld_p0;
    // Skid occupancy after this edge; a read is only launched when the byte
    // it returns next cycle is guaranteed a free entry even if nothing pops.
    occ_nxt    = {1'b0, fcnt} + {2'b00, push} - {2'b00, pop};
    issue_last = (rd_cnt == len - ADDR_W'(1));
    case (state)
      ST_IDLE: begin
        wr_en = i_wr_req;
        if (i_cmd_end && (i_send_num != '0)) begin
          accept_cmd = 1'b1;
          state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        busy_evt = i_wr_req | i_cmd_end;
        // Byte 0 is read during the ack cycle so the first beat lands two
        // cycles after the ack.
        if (i_tx_ack) begin
          issue     = 1'b1;
          state_nxt = ST_STREAM;
        end else if (timer == TMR_MAX) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        busy_evt = i_wr_req | i_cmd_end;
        issue    = (rd_cnt != len) && (occ_nxt < 3'd2);
        if (pop && e0_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    drop_inc = {1'b0, busy_evt} + {1'b0, timeout};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len      <= '0;
      rd_cnt   <= '0;
      timer    <= '0;
      fcnt     <= 2'd0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (accept_cmd) begin
        len    <= i_send_num;
        rd_cnt <= '0;
        timer  <= '0;
      end else begin
        if (state == ST_REQ) timer <= timer + TMR_W'(1);
        if (issue)           rd_cnt <= rd_cnt + ADDR_W'(1);
      end
      // Stage p0: RAM read data returns, tagged with its valid and last flags.
      vld_p0   <= issue;
      last_p0  <= issue_last;
      fcnt     <= occ_nxt[1:0];
      drop_cnt <= sat_add8(drop_cnt, drop_inc);
    end
  end

  // Stage p1: two-entry skid; e0 is the head presented on the output.
  always_ff @(posedge i_clk) begin
    case ({push, pop})
      2'b10: begin
        if (fcnt == 2'd0) begin
          e0_data <= data_p0;
          e0_last <= last_p0;
        end else begin
          e1_data <= data_p0;
          e1_last <= last_p0;
        end
      end
      2'b01: begin
        e0_data <= e1_data;
        e0_last <= e1_last;
      end
      2'b11: begin
        if (fcnt == 2'd1) begin
          e0_data <= data_p0;
          e0_last <= last_p0;
        end else begin
          e0_data <= e1_data;
          e0_last <= e1_last;
          e1_data <= data_p0;
          e1_last <= last_p0;
        end
      end
      default: ;
    endcase
  end

  assign o_tx_req   = (state == ST_REQ);
  assign o_tx_len   = len;
  assign o_tx_valid = (fcnt != 2'd0);
  assign o_tx_data  = o_tx_valid ? e0_data : '0;
  assign o_tx_last  = o_tx_valid & e0_last;
  assign o_busy     = (state != ST_IDLE);
  assign o_drop_cnt = drop_cnt;

endmodule
